// File: rtl/my_cond_stage.sv
// Condition-code stage: classifies ALU result words (zero/negative), resolves the
// jump decision, and buffers results in a 2-entry FIFO with a saturating taken-jump counter.
`timescale 1ns/1ps

module my_cond_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [2:0]       in_jmp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_zr,
  output logic             out_ng,
  output logic             out_jump,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef struct packed {
    logic [15:0] data;
    logic        zr;
    logic        ng;
    logic        jump;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // live_q keeps in_ready low until the first edge after reset release,
  // so in_ready stays a pure function of registered state.
  logic             live_q,      live_d;
  logic [1:0]       count_q,     count_d;
  logic             wr_ptr_q,    wr_ptr_d;
  logic             rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  entry_t           mem_q [2];

  entry_t new_entry;
  entry_t head;
  logic   push;
  logic   pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    new_entry      = '0;
    new_entry.data = in_data;
    new_entry.zr   = ~|in_data;
    new_entry.ng   = in_data[15];
    // in_jmp = {j1 (negative), j2 (zero), j3 (positive)}
    new_entry.jump = (in_jmp[2] & new_entry.ng)
                   | (in_jmp[1] & new_entry.zr)
                   | (in_jmp[0] & ~new_entry.zr & ~new_entry.ng);
  end

  always_comb begin
    in_ready  = live_q && (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    head      = mem_q[rd_ptr_q];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Empty FIFO drives all-zero outputs regardless of stale storage contents.
  always_comb begin
    out_data = '0;
    out_zr   = 1'b0;
    out_ng   = 1'b0;
    out_jump = 1'b0;
    if (out_valid) begin
      out_data = head.data;
      out_zr   = head.zr;
      out_ng   = head.ng;
      out_jump = head.jump;
    end
  end

  always_comb begin
    live_d   = 1'b1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (clr_cnt) begin
      taken_cnt_d = '0;
    end else if (pop && head.jump && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_ONE;
    end
  end

  assign taken_cnt = taken_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= 1'b0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      live_q      <= live_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // NOTE: storage is not reset; entries are only observable through count_q, which is.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

endmodule
